// File: rtl/shift_pkg.sv
// Opcodes and opcode classification shared by the shifter pipeline and its mux levels.
// Pure definitions: no timing and no handshake of its own.
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  function automatic logic op_is_right(input logic [2:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic op_is_rot(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_level.sv
// One barrel-shifter mux level: moves data by DIST positions when en is set, zero latency.
// Purely combinational; no flow control.
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] q
);

  logic fill;

  always_comb begin
    q    = d;
    fill = (op == OP_SRA) ? sign : 1'b0;
    if (en) begin
      // Reserved opcodes fall through every branch and pass data unchanged.
      if (op_is_rot(op)) begin
        q = op_is_right(op) ? {d[DIST-1:0], d[WIDTH-1:DIST]}
                            : {d[WIDTH-DIST-1:0], d[WIDTH-1:WIDTH-DIST]};
      end else if (op_is_right(op)) begin
        q = {{DIST{fill}}, d[WIDTH-1:DIST]};
      end else if (op == OP_SLL) begin
        q = {d[WIDTH-DIST-1:0], {DIST{1'b0}}};
      end
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined shifter/rotator; latency 1 + (SA_W-1)/REG_EVERY cycles, one result per cycle.
// Stall-tolerant: stages advance only into free or draining successors; flush kills all in flight.
module pipe_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_d,
  input  logic [$clog2(WIDTH)-1:0] in_sa,
  input  logic [2:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sh,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero
);

  localparam int SA_W = $clog2(WIDTH);
  localparam int NS   = 1 + (SA_W - 1) / REG_EVERY;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dat;
    logic [SA_W-1:0]  sa;
    logic [2:0]       op;
    logic             sign;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t           stg_q   [NS];
  stage_t           stg_d   [NS];
  stage_t           src     [NS];
  logic [WIDTH-1:0] stg_res [NS];
  logic [NS-1:0]    load;

  // Walk back from the output: a stage may load if empty or if its successor drains it.
  always_comb begin : ready_chain
    logic take;
    load = '0;
    take = out_ready;
    for (int s = NS - 1; s >= 0; s--) begin
      load[s] = !stg_q[s].vld || take;
      take    = load[s];
    end
  end

  assign in_ready = !flush && load[0];

  always_comb begin
    src[0].vld  = in_valid && in_ready;
    src[0].dat  = in_d;
    src[0].sa   = in_sa;
    src[0].op   = in_op;
    src[0].sign = in_d[WIDTH-1];
    src[0].tag  = in_tag;
    for (int s = 1; s < NS; s++) begin
      src[s] = stg_q[s-1];
    end
  end

  for (genvar k = 0; k < SA_W; k++) begin : g_lvl
    localparam int S = k / REG_EVERY;
    logic [WIDTH-1:0] lvl_in;
    logic [WIDTH-1:0] lvl_q;

    if (k == S * REG_EVERY) begin : g_first
      assign lvl_in = src[S].dat;
    end else begin : g_chain
      assign lvl_in = g_lvl[k-1].lvl_q;
    end

    shift_level #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_level (
      .d   (lvl_in),
      .en  (src[S].sa[k]),
      .op  (src[S].op),
      .sign(src[S].sign),
      .q   (lvl_q)
    );
  end

  // The last stage absorbs any leftover levels and doubles as the output register.
  for (genvar s = 0; s < NS; s++) begin : g_stg
    localparam int HI = (s == NS - 1) ? SA_W - 1 : (s + 1) * REG_EVERY - 1;
    assign stg_res[s] = g_lvl[HI].lvl_q;
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      stg_d[s] = stg_q[s];
      if (load[s]) begin
        stg_d[s]     = src[s];
        stg_d[s].dat = stg_res[s];
      end
      if (flush) begin
        stg_d[s].vld = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (rst) begin
        stg_q[s] <= '0;
      end else begin
        stg_q[s] <= stg_d[s];
      end
    end
  end

  assign out_valid = stg_q[NS-1].vld;
  assign out_sh    = stg_q[NS-1].dat;
  assign out_tag   = stg_q[NS-1].tag;
  assign out_zero  = ~|stg_q[NS-1].dat;

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: directed scenarios plus a randomized stream against a queue model,
// on the default configuration and on a single-cycle (REG_EVERY = 5) instance.
module tb_pipe_shifter;

  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b011;
  localparam logic [2:0] ROL = 3'b100;
  localparam logic [2:0] ROR = 3'b101;

  typedef struct packed {
    logic [31:0] sh;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_d, out_sh;
  logic [4:0]  in_sa, in_tag, out_tag;
  logic [2:0]  in_op;

  logic        r5_flush, r5_in_valid, r5_in_ready, r5_out_valid, r5_out_ready, r5_out_zero;
  logic [31:0] r5_in_d, r5_out_sh;
  logic [4:0]  r5_in_sa, r5_in_tag, r5_out_tag;
  logic [2:0]  r5_in_op;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_shifter #(.WIDTH(32), .REG_EVERY(2), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_d(in_d), .in_sa(in_sa), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sh(out_sh),
    .out_tag(out_tag), .out_zero(out_zero)
  );

  pipe_shifter #(.WIDTH(32), .REG_EVERY(5), .TAG_W(5)) dut_r5 (
    .clk(clk), .rst(rst), .flush(r5_flush), .in_valid(r5_in_valid), .in_ready(r5_in_ready),
    .in_d(r5_in_d), .in_sa(r5_in_sa), .in_op(r5_in_op), .in_tag(r5_in_tag),
    .out_valid(r5_out_valid), .out_ready(r5_out_ready), .out_sh(r5_out_sh),
    .out_tag(r5_out_tag), .out_zero(r5_out_zero)
  );

  // Reference: whole-word arithmetic straight from the opcode definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sa, input logic [2:0] op);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      SLL:     return d << sa;
      SRL:     return d >> sa;
      SRA:     return 32'($signed(d) >>> sa);
      ROL:     begin dd = dd << sa; return dd[63:32]; end
      ROR:     begin dd = dd >> sa; return dd[31:0]; end
      default: return d;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_d = '0; in_sa = '0; in_op = '0; in_tag = '0;
  endtask

  task automatic offer(input logic [31:0] d, input logic [4:0] sa, input logic [2:0] op, input logic [4:0] tag);
    in_valid = 1'b1; in_d = d; in_sa = sa; in_op = op; in_tag = tag;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_sh, out_tag, out_zero, in_ready} !== {1'b0, 32'h0, 5'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: vld=%b sh=%h tag=%0d zero=%b rdy=%b want 0 00000000 0 1 1",
               out_valid, out_sh, out_tag, out_zero, in_ready);
    end
  endtask

  task automatic test_sra_latency();
    int lat;
    idle();
    offer(32'h8000_0010, 5'd4, SRA, 5'd7);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL sra_accept: in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    n_vec++;
    if (lat != 3) begin
      n_err++; $display("FAIL sra_latency: got %0d cycles want 3", lat);
    end
    n_vec++;
    if ({out_valid, out_sh, out_tag, out_zero} !== {1'b1, 32'hF800_0001, 5'd7, 1'b0}) begin
      n_err++;
      $display("FAIL sra_result: vld=%b sh=%h tag=%0d zero=%b want 1 f8000001 7 0",
               out_valid, out_sh, out_tag, out_zero);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL sra_consumed: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tv_d   [3];
    logic [4:0]  tv_sa  [3];
    logic [2:0]  tv_op  [3];
    logic [31:0] tv_exp [3];
    int          got_c  [3];
    logic [31:0] got_sh [3];
    int          n;
    tv_d   = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0001};
    tv_sa  = '{5'd31, 5'd31, 5'd1};
    tv_op  = '{SLL, SRL, ROR};
    tv_exp = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
    got_c  = '{-1, -1, -1};
    got_sh = '{32'h0, 32'h0, 32'h0};
    n = 0;
    idle();
    for (int c = 0; c < 10; c++) begin
      if (c < 3) offer(tv_d[c], tv_sa[c], tv_op[c], 5'(c));
      else in_valid = 1'b0;
      #1;
      if (c < 3) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("FAIL b2b_accept[%0d]: in_ready=%b want 1", c, in_ready);
        end
      end
      if (out_valid === 1'b1) begin
        if (n < 3) begin got_c[n] = c; got_sh[n] = out_sh; end
        n++;
      end
      tick();
    end
    n_vec++;
    if (n != 3) begin
      n_err++; $display("FAIL b2b_count: got %0d results want 3", n);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (got_c[i] != 3 + i || got_sh[i] !== tv_exp[i]) begin
        n_err++;
        $display("FAIL b2b_result[%0d]: cycle %0d sh %h want cycle %0d sh %h",
                 i, got_c[i], got_sh[i], 3 + i, tv_exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] sd  [8];
    logic [4:0]  ssa [8];
    logic [2:0]  sop [8];
    exp_t        e;
    int          idx, got;
    sd[0] = 32'h1234_5678; ssa[0] = 5'd8; sop[0] = ROL;
    for (int i = 1; i < 8; i++) begin
      sd[i] = $urandom; ssa[i] = 5'($urandom_range(0, 31)); sop[i] = 3'($urandom_range(0, 7));
    end
    exp_q.delete();
    idle();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      offer(sd[idx], ssa[idx], sop[idx], 5'(idx + 1));
      #1;
      if (c >= 3) begin
        n_vec++;
        if ({out_valid, out_sh, out_tag, in_ready} !== {1'b1, 32'h3456_7812, 5'd1, 1'b0}) begin
          n_err++;
          $display("FAIL stall_hold[%0d]: vld=%b sh=%h tag=%0d rdy=%b want 1 34567812 1 0",
                   c, out_valid, out_sh, out_tag, in_ready);
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        e.sh = ref_shift(sd[idx], int'(ssa[idx]), sop[idx]);
        e.tag = 5'(idx + 1);
        exp_q.push_back(e);
        idx++;
      end
      tick();
    end
    n_vec++;
    if (idx != 3) begin
      n_err++; $display("FAIL stall_accepts: got %0d want 3", idx);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stall_extra: sh=%h tag=%0d want none", out_sh, out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_sh, out_tag} !== {e.sh, e.tag}) begin
            n_err++;
            $display("FAIL stall_drain: sh=%h tag=%0d want %h %0d", out_sh, out_tag, e.sh, e.tag);
          end
        end
        got++;
      end
      tick();
    end
    n_vec++;
    if (got != 3) begin
      n_err++; $display("FAIL stall_count: got %0d results want 3", got);
    end
  endtask

  task automatic test_flush();
    int seen;
    idle();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      offer($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 5'(c + 10));
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL flush_fill[%0d]: in_ready=%b want 1", c, in_ready);
      end
      tick();
    end
    offer(32'hCAFE_F00D, 5'd3, SLL, 5'd13);
    flush = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_full_rdy: in_ready=%b want 0", in_ready);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_next: out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL flush_killed: %0d results emerged want 0", seen);
    end
    // Empty pipeline, free output: only the flush term can hold in_ready low.
    offer(32'h0000_00FF, 5'd1, SLL, 5'd20);
    flush = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_empty_rdy: in_ready=%b want 0", in_ready);
    end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL flush_offer_dropped: %0d results emerged want 0", seen);
    end
  endtask

  task automatic test_edges();
    logic [31:0] ed  [9];
    logic [4:0]  esa [9];
    logic [2:0]  eop [9];
    logic [31:0] eex [9];
    int          idx, ridx;
    ed  = '{32'hFFFF_FFFF, 32'h0000_000F, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h0123_4567,
            32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0001, 32'h8000_0001};
    esa = '{5'd0, 5'd4, 5'd13, 5'd7, 5'd31, 5'd31, 5'd31, 5'd0, 5'd31};
    eop = '{SLL, SRL, 3'b110, 3'b010, 3'b111, SRA, SRA, ROL, ROR};
    eex = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'h0123_4567,
            32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0003};
    idle();
    idx = 0;
    ridx = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 9) offer(ed[idx], esa[idx], eop[idx], 5'(idx));
      else in_valid = 1'b0;
      #1;
      if (out_valid === 1'b1) begin
        n_vec++;
        if (ridx >= 9) begin
          n_err++; $display("FAIL edge_extra: sh=%h tag=%0d want none", out_sh, out_tag);
        end else if ({out_sh, out_tag, out_zero} !== {eex[ridx], 5'(ridx), (eex[ridx] == 32'h0)}) begin
          n_err++;
          $display("FAIL edge[%0d]: sh=%h tag=%0d zero=%b want %h %0d %b",
                   ridx, out_sh, out_tag, out_zero, eex[ridx], ridx, (eex[ridx] == 32'h0));
        end
        ridx++;
      end
      if (in_valid && in_ready === 1'b1) idx++;
      tick();
    end
    n_vec++;
    if (ridx != 9) begin
      n_err++; $display("FAIL edge_count: got %0d results want 9", ridx);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    idle();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      offer(32'hFFFF_0000 | 32'(c), 5'd2, ROL, 5'(c + 1));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_sh, out_tag, out_zero, in_ready} !== {1'b0, 32'h0, 5'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid: vld=%b sh=%h tag=%0d zero=%b rdy=%b want 0 00000000 0 1 1",
               out_valid, out_sh, out_tag, out_zero, in_ready);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++; $display("FAIL reset_mid_killed: %0d results emerged want 0", seen);
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [38:0] held;
    logic        prev_stall;
    logic [31:0] d;
    logic [4:0]  sa, tag;
    logic [2:0]  op;
    int          cnt;
    exp_q.delete();
    idle();
    prev_stall = 1'b0;
    held = '0;
    for (int c = 0; c < 600; c++) begin
      d = $urandom; sa = 5'($urandom_range(0, 31)); op = 3'($urandom_range(0, 7));
      tag = 5'($urandom_range(0, 31));
      in_d = d; in_sa = sa; in_op = op; in_tag = tag;
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      if (prev_stall) begin
        n_vec++;
        if ({out_valid, out_sh, out_tag, out_zero} !== held) begin
          n_err++;
          $display("FAIL rnd_hold[%0d]: got %h want %h", c, {out_valid, out_sh, out_tag, out_zero}, held);
        end
      end
      if (flush) begin
        n_vec++;
        if (in_ready !== 1'b0) begin
          n_err++; $display("FAIL rnd_flush_rdy[%0d]: in_ready=%b want 0", c, in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_extra[%0d]: sh=%h tag=%0d want none", c, out_sh, out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_sh, out_tag, out_zero} !== {e.sh, e.tag, (e.sh == 32'h0)}) begin
            n_err++;
            $display("FAIL rnd_result[%0d]: sh=%h tag=%0d zero=%b want %h %0d %b",
                     c, out_sh, out_tag, out_zero, e.sh, e.tag, (e.sh == 32'h0));
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && !out_ready && !flush;
      held = {out_valid, out_sh, out_tag, out_zero};
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && in_ready === 1'b1) begin
        e.sh = ref_shift(d, int'(sa), op);
        e.tag = tag;
        exp_q.push_back(e);
      end
      tick();
    end
    idle();
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      #1;
      if (out_valid === 1'b1) begin
        n_vec++;
        e = exp_q.pop_front();
        if ({out_sh, out_tag} !== {e.sh, e.tag}) begin
          n_err++;
          $display("FAIL rnd_drain: sh=%h tag=%0d want %h %0d", out_sh, out_tag, e.sh, e.tag);
        end
      end
      tick();
      cnt++;
    end
    n_vec++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_leftover: %0d results missing, out_valid=%b want 0 and 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_single_cycle();
    logic [31:0] d;
    logic [4:0]  sa, tag;
    logic [2:0]  op;
    logic [31:0] prev_sh;
    logic [4:0]  prev_tag;
    r5_flush = 1'b0; r5_out_ready = 1'b1;
    r5_in_valid = 1'b1; r5_in_d = 32'h8000_0010; r5_in_sa = 5'd4; r5_in_op = SRA; r5_in_tag = 5'd7;
    #1;
    n_vec++;
    if (r5_in_ready !== 1'b1) begin
      n_err++; $display("FAIL r5_accept: in_ready=%b want 1", r5_in_ready);
    end
    tick();
    r5_in_valid = 1'b0;
    n_vec++;
    if ({r5_out_valid, r5_out_sh, r5_out_tag, r5_out_zero} !== {1'b1, 32'hF800_0001, 5'd7, 1'b0}) begin
      n_err++;
      $display("FAIL r5_sra: vld=%b sh=%h tag=%0d zero=%b want 1 f8000001 7 0",
               r5_out_valid, r5_out_sh, r5_out_tag, r5_out_zero);
    end
    prev_sh = '0;
    prev_tag = '0;
    for (int c = 0; c <= 20; c++) begin
      d = $urandom; sa = 5'($urandom_range(0, 31)); op = 3'($urandom_range(0, 7));
      tag = 5'($urandom_range(0, 31));
      r5_in_valid = (c < 20);
      r5_in_d = d; r5_in_sa = sa; r5_in_op = op; r5_in_tag = tag;
      #1;
      if (c > 0) begin
        n_vec++;
        if ({r5_out_valid, r5_out_sh, r5_out_tag} !== {1'b1, prev_sh, prev_tag}) begin
          n_err++;
          $display("FAIL r5_stream[%0d]: vld=%b sh=%h tag=%0d want 1 %h %0d",
                   c, r5_out_valid, r5_out_sh, r5_out_tag, prev_sh, prev_tag);
        end
      end
      prev_sh = ref_shift(d, int'(sa), op);
      prev_tag = tag;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    r5_flush = 1'b0; r5_in_valid = 1'b0; r5_out_ready = 1'b1;
    r5_in_d = '0; r5_in_sa = '0; r5_in_op = '0; r5_in_tag = '0;
    test_reset();
    test_sra_latency();
    test_back_to_back();
    test_stall();
    test_flush();
    test_edges();
    test_reset_mid();
    test_random();
    test_single_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_shifter.md
Name: pipe_shifter

Overview:
- Parametrised, pipelined barrel shifter/rotator for the integer execute path.
- Successor to the single-cycle combinational shifter. Adds:
  - configurable data width;
  - configurable pipeline depth;
  - rotate modes;
  - valid/ready flow control;
  - a tag carried alongside each operation;
  - a flush input, so in-flight shifts can be killed on an interrupt or exception.

Parameters:
- WIDTH, 32: data width. Must be a power of two and at least 4.
- REG_EVERY, 2: number of mux levels between internal pipeline registers. A value of $clog2(WIDTH) or more gives single-cycle latency.
- TAG_W, 5: width of the tag carried through the pipeline (destination register number).

Ports:
- clk, in, 1: clock. All state changes on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: kills every in-flight operation and the operation being offered this cycle.
- in_valid, in, 1: an operation is offered on in_d, in_sa, in_op and in_tag.
- in_ready, out, 1: the shifter accepts an offered operation this cycle.
- in_d, in, WIDTH: operand to shift.
- in_sa, in, $clog2(WIDTH): shift amount. Unsigned; only these bits are used.
- in_op, in, 3: operation code, see Behaviour.
- in_tag, in, TAG_W: tag returned unchanged with the result.
- out_valid, out, 1: a result is available.
- out_ready, in, 1: the consumer takes the result this cycle.
- out_sh, out, WIDTH: shifted result.
- out_tag, out, TAG_W: tag of the operation that produced out_sh.
- out_zero, out, 1: high when out_sh is all zeros.

Behaviour:
- Operation codes:
  - 000 SLL: shift left, zero fill.
  - 001 SRL: shift right, zero fill.
  - 011 SRA: shift right, each vacated bit takes in_d[WIDTH-1] as captured at input.
  - 100 ROL: rotate left.
  - 101 ROR: rotate right.
  - 010, 110, 111: reserved; out_sh = in_d unchanged.
- in_sa = 0 returns in_d unchanged for every operation code.
- Structure:
  - SA_W = $clog2(WIDTH) mux levels. Level k moves the data by 2^k positions when sa[k] = 1.
  - An internal register follows level k when (k+1) % REG_EVERY == 0 and k < SA_W-1.
  - The result is always registered at the output.
- Latency: L = 1 + floor((SA_W-1)/REG_EVERY) cycles from acceptance to out_valid, with no stall. For the defaults (WIDTH 32, REG_EVERY 2) L = 3.
- Each stage register holds:
  - a valid bit;
  - the partial data;
  - the remaining shift-amount bits;
  - the operation code;
  - the sign bit captured at input;
  - the tag.
- Handshake and throughput:
  - A stage advances when its successor is empty or is itself advancing. The output stage advances when out_valid && out_ready.
  - in_ready = !flush && (first stage empty || first stage advancing). The term is combinational and includes out_ready.
  - An operation is accepted on in_valid && in_ready.
  - Full throughput is one result per cycle while out_ready stays high.
- Stall behaviour:
  - While out_valid && !out_ready, out_sh, out_tag and out_zero are held stable.
  - Bubbles ahead of the stall are squeezed out; no operation is lost or duplicated.
- Flush:
  - The cycle after flush is high, every valid bit is 0 and out_valid = 0.
  - The operation offered during flush is not accepted, because in_ready is 0.
  - Data registers need not be cleared.
- Simultaneous flush and out_ready: the current output counts as consumed, and nothing new appears.
- Reset:
  - All valid bits clear; out_valid = 0, out_sh = 0, out_tag = 0, out_zero = 1.
  - in_ready = 1 in the first cycle after rst is released, provided flush = 0.
  - A reset in the middle of a run discards all in-flight operations, exactly as flush does.
- out_zero is computed from the registered result; it adds no extra latency.
- Ordering: results leave in acceptance order.

Decomposition:
- Shared package shift_pkg holds:
  - the localparams OP_SLL = 3'b000, OP_SRL = 3'b001, OP_SRA = 3'b011, OP_ROL = 3'b100, OP_ROR = 3'b101;
  - a function op_is_right(op) and a function op_is_rot(op).
- Sub-module shift_level (parameters WIDTH, DIST): one combinational mux level.
  - Inputs: data, enable bit, op, sign.
  - It is instantiated SA_W times from a generate loop. Pipeline registers and handshake logic live in pipe_shifter.

Test Plan:
- After reset with out_ready = 1, offer SRA, in_d = 0x80000010, in_sa = 4, tag 7 -> after 3 cycles out_valid = 1, out_sh = 0xF8000001, out_tag = 7, out_zero = 0.
- Offer back-to-back SLL 0x00000001 by 31, SRL 0x80000000 by 31, and ROR 0x00000001 by 1 -> results on 3 consecutive cycles: 0x80000000, 0x00000001, 0x80000000. Results appear in order.
- Offer ROL 0x12345678 by 8 and hold out_ready = 0 for 5 cycles -> out_sh = 0x34567812 held stable. in_ready drops once the pipeline is full. No loss or duplication after out_ready returns to 1.
- Fill the pipeline with 3 operations, then raise flush for one cycle while in_valid = 1 -> next cycle out_valid = 0. in_ready = 0 during the flush cycle. None of the 4 operations ever emerges.
- Offer SLL 0xFFFFFFFF by 0, then SRL 0x0000000F by 4 -> out_sh = 0xFFFFFFFF, then 0x00000000 with out_zero = 1. Offer reserved op 110 on 0xDEADBEEF -> out_sh = 0xDEADBEEF.
- Assert rst for 1 cycle mid-stream -> out_valid = 0, out_sh = 0, out_tag = 0, out_zero = 1. Re-run the first scenario with REG_EVERY = 5 -> single-cycle latency, same results.
